// File: rtl/cpu_bus_responder_if.sv
// Signal bundle shared by the CPU microcode, the memory-side bus responder and the memory port.
// The slave modport is the responder's view; the master modport is the CPU/memory view.
interface cpu_bus_responder_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8
);
  logic [3:0]            cycle_step;
  logic                  address_out;
  logic [ADDR_WIDTH-1:0] address;
  logic                  bus_out;
  logic                  bus_in;
  logic [DATA_WIDTH-1:0] data_wr;
  logic [DATA_WIDTH-1:0] data_rd;
  logic                  data_valid;
  logic                  stall;
  logic                  bus_error;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  mem_wr;
  logic                  mem_rd;
  logic                  mem_ready;
  logic [DATA_WIDTH-1:0] mem_rdata;

  modport slave (
    input  cycle_step, address_out, address, bus_out, bus_in, data_wr,
    input  mem_ready, mem_rdata,
    output data_rd, data_valid, stall, bus_error,
    output mem_addr, mem_wdata, mem_wr, mem_rd
  );

  modport master (
    output cycle_step, address_out, address, bus_out, bus_in, data_wr,
    output mem_ready, mem_rdata,
    input  data_rd, data_valid, stall, bus_error,
    input  mem_addr, mem_wdata, mem_wr, mem_rd
  );
endinterface

// File: rtl/cpu_bus_responder.sv
// Memory-side end of the CPU load/store bus: latches the address M-cycle, runs the data
// transfer against a ready/valid memory port, stalls the CPU on wait states, times out to open bus.
module cpu_bus_responder #(
  parameter int ADDR_WIDTH     = 16,
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic                  i_Clk,
  input  logic                  i_Rst_n,
  cpu_bus_responder_if.slave    bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    WRITE = 2'd2,
    READ  = 2'd3
  } state_t;

  localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] TMO_LAST =
    CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [DATA_WIDTH-1:0] OPEN_BUS = '1;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  data_valid_q, data_valid_d;
  logic                  bus_error_q, bus_error_d;
  logic                  mem_wr_q, mem_wr_d;
  logic                  mem_rd_q, mem_rd_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  logic strobe;
  logic access;
  logic timed_out;
  logic unused_step;

  assign strobe      = bus.address_out & bus.cycle_step[1];
  assign access      = bus.cycle_step[0] & (bus.bus_out | bus.bus_in);
  assign timed_out   = (TIMEOUT_CYCLES != 0) && (cnt_q == TMO_LAST);
  assign unused_step = ^bus.cycle_step[3:2];

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      wdata_q      <= '0;
      data_q       <= '0;
      data_valid_q <= 1'b0;
      bus_error_q  <= 1'b0;
      mem_wr_q     <= 1'b0;
      mem_rd_q     <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      data_q       <= data_d;
      data_valid_q <= data_valid_d;
      bus_error_q  <= bus_error_d;
      mem_wr_q     <= mem_wr_d;
      mem_rd_q     <= mem_rd_d;
      cnt_q        <= cnt_d;
    end
  end

  // An access in ARMED takes priority over a same-edge strobe so it uses the old address.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    data_d       = data_q;
    data_valid_d = 1'b0;
    bus_error_d  = 1'b0;
    cnt_d        = cnt_q;

    case (state_q)
      IDLE: begin
        if (access) begin
          bus_error_d = 1'b1;
        end else if (strobe) begin
          addr_d  = bus.address;
          state_d = ARMED;
        end
      end

      ARMED: begin
        if (access) begin
          cnt_d = '0;
          if (bus.bus_out) begin
            wdata_d     = bus.data_wr;
            bus_error_d = bus.bus_in;
            state_d     = WRITE;
          end else begin
            state_d = READ;
          end
        end else if (strobe) begin
          addr_d = bus.address;
        end
      end

      WRITE: begin
        if (bus.mem_ready) begin
          state_d = IDLE;
        end else if (timed_out) begin
          bus_error_d = 1'b1;
          state_d     = IDLE;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      READ: begin
        if (bus.mem_ready) begin
          data_d       = bus.mem_rdata;
          data_valid_d = 1'b1;
          state_d      = IDLE;
        end else if (timed_out) begin
          data_d       = OPEN_BUS;
          data_valid_d = 1'b1;
          bus_error_d  = 1'b1;
          state_d      = IDLE;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase

    mem_wr_d = (state_d == WRITE);
    mem_rd_d = (state_d == READ);
  end

  assign bus.mem_addr   = addr_q;
  assign bus.mem_wdata  = wdata_q;
  assign bus.mem_wr     = mem_wr_q;
  assign bus.mem_rd     = mem_rd_q;
  assign bus.data_rd    = data_q;
  assign bus.data_valid = data_valid_q;
  assign bus.bus_error  = bus_error_q;
  assign bus.stall      = (mem_wr_q | mem_rd_q) & ~bus.mem_ready;

endmodule

// File: tb/tb_cpu_bus_responder.sv
// Directed bench for cpu_bus_responder: write, wait-state read, read timeout,
// protocol errors and asynchronous reset in the middle of a request.
module tb_cpu_bus_responder;

  logic i_Clk;
  logic i_Rst_n;
  int   compareCount;
  int   failCount;

  cpu_bus_responder_if #(.ADDR_WIDTH(16), .DATA_WIDTH(8)) bus ();

  cpu_bus_responder #(
    .ADDR_WIDTH(16),
    .DATA_WIDTH(8),
    .TIMEOUT_CYCLES(15)
  ) dut (
    .i_Clk  (i_Clk),
    .i_Rst_n(i_Rst_n),
    .bus    (bus.slave)
  );

  initial begin
    i_Clk = 1'b0;
    forever #5 i_Clk = ~i_Clk;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [15:0] got, input logic [15:0] exp);
    compareCount++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_Clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [3:0] step, input logic aout, input logic [15:0] addr,
                               input logic bo, input logic bi, input logic [7:0] d);
    bus.cycle_step  = step;
    bus.address_out = aout;
    bus.address     = addr;
    bus.bus_out     = bo;
    bus.bus_in      = bi;
    bus.data_wr     = d;
    tick();
    bus.cycle_step  = 4'b0000;
    bus.address_out = 1'b0;
    bus.bus_out     = 1'b0;
    bus.bus_in      = 1'b0;
  endtask

  initial begin
    compareCount    = 0;
    failCount       = 0;
    i_Rst_n         = 1'b0;
    bus.cycle_step  = 4'b0000;
    bus.address_out = 1'b0;
    bus.address     = 16'h0000;
    bus.bus_out     = 1'b0;
    bus.bus_in      = 1'b0;
    bus.data_wr     = 8'h00;
    bus.mem_ready   = 1'b0;
    bus.mem_rdata   = 8'h00;

    tick();
    checkOutput("rst_mem_wr", 16'(bus.mem_wr), 16'h0);
    checkOutput("rst_mem_rd", 16'(bus.mem_rd), 16'h0);
    checkOutput("rst_data", 16'(bus.data_rd), 16'h0000);
    checkOutput("rst_stall", 16'(bus.stall), 16'h0);
    checkOutput("rst_mem_addr", bus.mem_addr, 16'h0000);
    i_Rst_n = 1'b1;
    tick();

    // Zero-wait write
    $display("[TB] zero-wait write to C000");
    bus.mem_ready = 1'b1;
    applyStimulus(4'b0010, 1'b1, 16'hC000, 1'b0, 1'b0, 8'h00);
    checkOutput("t1_armed_wr", 16'(bus.mem_wr), 16'h0);
    applyStimulus(4'b0001, 1'b0, 16'h0000, 1'b1, 1'b0, 8'h5A);
    checkOutput("t1_mem_wr", 16'(bus.mem_wr), 16'h1);
    checkOutput("t1_mem_addr", bus.mem_addr, 16'hC000);
    checkOutput("t1_wdata", 16'(bus.mem_wdata), 16'h005A);
    checkOutput("t1_stall", 16'(bus.stall), 16'h0);
    tick();
    checkOutput("t1_wr_done", 16'(bus.mem_wr), 16'h0);
    checkOutput("t1_no_err", 16'(bus.bus_error), 16'h0);

    // Read with three wait states
    $display("[TB] read FF80 with 3 wait states");
    bus.mem_ready = 1'b0;
    applyStimulus(4'b0010, 1'b1, 16'hFF80, 1'b0, 1'b0, 8'h00);
    applyStimulus(4'b0001, 1'b0, 16'h0000, 1'b0, 1'b1, 8'h00);
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("t2_stall_%0d", i), 16'(bus.stall), 16'h1);
      checkOutput($sformatf("t2_rd_%0d", i), 16'(bus.mem_rd), 16'h1);
      tick();
    end
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 8'h3C;
    #1;
    checkOutput("t2_stall_rel", 16'(bus.stall), 16'h0);
    checkOutput("t2_addr", bus.mem_addr, 16'hFF80);
    tick();
    checkOutput("t2_valid", 16'(bus.data_valid), 16'h1);
    checkOutput("t2_data", 16'(bus.data_rd), 16'h003C);
    checkOutput("t2_rd_drop", 16'(bus.mem_rd), 16'h0);
    bus.mem_ready = 1'b0;
    bus.mem_rdata = 8'h00;
    tick();
    checkOutput("t2_valid_pulse", 16'(bus.data_valid), 16'h0);
    checkOutput("t2_data_hold", 16'(bus.data_rd), 16'h003C);

    // Read timeout
    $display("[TB] read 8000 with no ready");
    applyStimulus(4'b0010, 1'b1, 16'h8000, 1'b0, 1'b0, 8'h00);
    applyStimulus(4'b0001, 1'b0, 16'h0000, 1'b0, 1'b1, 8'h00);
    checkOutput("t3_rd_start", 16'(bus.mem_rd), 16'h1);
    for (int i = 1; i < 15; i++) begin
      tick();
      checkOutput($sformatf("t3_rd_%0d", i), 16'(bus.mem_rd), 16'h1);
    end
    tick();
    checkOutput("t3_rd_drop", 16'(bus.mem_rd), 16'h0);
    checkOutput("t3_data_ff", 16'(bus.data_rd), 16'h00FF);
    checkOutput("t3_valid", 16'(bus.data_valid), 16'h1);
    checkOutput("t3_err", 16'(bus.bus_error), 16'h1);
    tick();
    checkOutput("t3_err_pulse", 16'(bus.bus_error), 16'h0);
    checkOutput("t3_valid_pulse", 16'(bus.data_valid), 16'h0);

    // Orphan access, last address wins, write/read conflict
    $display("[TB] protocol errors");
    bus.mem_ready = 1'b1;
    applyStimulus(4'b0001, 1'b0, 16'h0000, 1'b0, 1'b1, 8'h00);
    checkOutput("t4_orphan_err", 16'(bus.bus_error), 16'h1);
    checkOutput("t4_orphan_rd", 16'(bus.mem_rd), 16'h0);
    tick();
    checkOutput("t4_orphan_clr", 16'(bus.bus_error), 16'h0);
    applyStimulus(4'b0010, 1'b1, 16'h1234, 1'b0, 1'b0, 8'h00);
    applyStimulus(4'b0010, 1'b1, 16'hABCD, 1'b0, 1'b0, 8'h00);
    applyStimulus(4'b0001, 1'b0, 16'h0000, 1'b1, 1'b0, 8'h77);
    checkOutput("t4_last_addr", bus.mem_addr, 16'hABCD);
    checkOutput("t4_wr", 16'(bus.mem_wr), 16'h1);
    checkOutput("t4_wr_noerr", 16'(bus.bus_error), 16'h0);
    tick();
    applyStimulus(4'b0010, 1'b1, 16'h4321, 1'b0, 1'b0, 8'h00);
    applyStimulus(4'b0001, 1'b0, 16'h0000, 1'b1, 1'b1, 8'h99);
    checkOutput("t4_conf_wr", 16'(bus.mem_wr), 16'h1);
    checkOutput("t4_conf_rd", 16'(bus.mem_rd), 16'h0);
    checkOutput("t4_conf_err", 16'(bus.bus_error), 16'h1);
    checkOutput("t4_conf_wdata", 16'(bus.mem_wdata), 16'h0099);
    tick();
    checkOutput("t4_conf_done", 16'(bus.mem_wr), 16'h0);
    checkOutput("t4_conf_errclr", 16'(bus.bus_error), 16'h0);

    // Asynchronous reset during a read
    $display("[TB] reset during read");
    bus.mem_ready = 1'b0;
    applyStimulus(4'b0010, 1'b1, 16'h2000, 1'b0, 1'b0, 8'h00);
    applyStimulus(4'b0001, 1'b0, 16'h0000, 1'b0, 1'b1, 8'h00);
    checkOutput("t5_rd_pre", 16'(bus.mem_rd), 16'h1);
    #2;
    i_Rst_n = 1'b0;
    #1;
    checkOutput("t5_rst_rd", 16'(bus.mem_rd), 16'h0);
    checkOutput("t5_rst_data", 16'(bus.data_rd), 16'h0000);
    checkOutput("t5_rst_stall", 16'(bus.stall), 16'h0);
    checkOutput("t5_rst_addr", bus.mem_addr, 16'h0000);
    tick();
    i_Rst_n = 1'b1;
    tick();
    bus.mem_ready = 1'b1;
    applyStimulus(4'b0010, 1'b1, 16'h0042, 1'b0, 1'b0, 8'h00);
    applyStimulus(4'b0001, 1'b0, 16'h0000, 1'b1, 1'b0, 8'h11);
    checkOutput("t5_post_wr", 16'(bus.mem_wr), 16'h1);
    checkOutput("t5_post_addr", bus.mem_addr, 16'h0042);
    tick();
    bus.mem_rdata = 8'hA5;
    applyStimulus(4'b0010, 1'b1, 16'h0043, 1'b0, 1'b0, 8'h00);
    applyStimulus(4'b0001, 1'b0, 16'h0000, 1'b0, 1'b1, 8'h00);
    checkOutput("t5_post_rd", 16'(bus.mem_rd), 16'h1);
    tick();
    checkOutput("t5_post_valid", 16'(bus.data_valid), 16'h1);
    checkOutput("t5_post_data", 16'(bus.data_rd), 16'h00A5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
    $finish;
  end

endmodule
